// File: rtl/uart_pkg.sv
// Purpose : shared constants and the assembler state type for the UART receive path.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package uart_pkg;

    localparam int DATA_BITS = 8;
    // Wide enough to hold a count of 0..DATA_BITS.
    localparam int CNT_W     = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_STOP
    } asm_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Purpose : synchronous first-in-first-out store for received bytes, head shown combinationally.
// Latency : a pushed entry is visible on head the cycle after the push when the FIFO was empty.
// Backpressure : a push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (async active-low); push/push_data write the tail; pop
// removes the head; full/empty report occupancy; head is the oldest entry.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_byte_assembler.sv
// Purpose : assembles LSB-first UART data bits into bytes and stores good frames for the host.
// Latency : data_out_valid rises the cycle after done when storage was empty.
// Backpressure : valid/ready pop; a good byte arriving to full storage (no same-cycle pop) is dropped and flags overrun_err.
//
// Ports: clk, rst_n (async active-low); bit_ready/rx_bit deliver data bits;
// done ends a frame, framing_err marks a bad stop bit; err_clr clears the
// sticky frame_err/overrun_err; data_out/data_out_valid/data_out_ready is the
// host side. Macro UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of
// the single holding register.
module rx_byte_assembler
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_ready,
    input  logic                 rx_bit,
    input  logic                 done,
    input  logic                 framing_err,
    input  logic                 err_clr,
    input  logic                 data_out_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    asm_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push;
    logic                 frame_set;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 overrun_set;

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        // done outranks a coincident bit_ready; a short frame is simply dropped.
        if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
            if (state_q == WAIT_STOP) begin
                if (framing_err) begin
                    frame_set = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
        end else if (bit_ready) begin
            case (state_q)
                IDLE: begin
                    state_d = COLLECT;
                    shift_d = {rx_bit, {(DATA_BITS - 1){1'b0}}};
                    cnt_d   = CNT_ONE;
                end
                COLLECT: begin
                    shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = WAIT_STOP;
                    end
                end
                default: ;  // WAIT_STOP ignores extra bits until done
            endcase
        end
    end

    // ---------------- storage ----------------
    assign pop         = data_out_valid && data_out_ready;
    assign push_ok     = push && (!full || pop);
    assign overrun_set = push && !push_ok;

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .full      (full),
        .empty     (fifo_empty),
        .head      (data_out)
    );

    assign data_out_valid = !fifo_empty;
`else
    logic [DATA_BITS-1:0] hold_dat;
    logic                 hold_vld;

    // FIFO_DEPTH has no effect on the single-register build.
    if (FIFO_DEPTH > 0) begin : g_depth_unused
    end

    assign full           = hold_vld;
    assign data_out       = hold_dat;
    assign data_out_valid = hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_dat <= '0;
            hold_vld <= 1'b0;
        end else if (push_ok) begin
            hold_dat <= shift_q;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Purpose : self-checking bench for rx_byte_assembler: directed frames plus randomized strobes against a queue model.
// Latency : outputs compared every cycle at the falling edge after the model has absorbed the rising edge.
// Backpressure : data_out_ready driven both directed and randomly to exercise pops, full storage and overrun.
module tb_rx_byte_assembler;

`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_ready = 1'b0;
    logic       rx_bit = 1'b0;
    logic       done = 1'b0;
    logic       framing_err = 1'b0;
    logic       err_clr = 1'b0;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;
    logic       overrun_err;

    rx_byte_assembler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bit_ready      (bit_ready),
        .rx_bit         (rx_bit),
        .done           (done),
        .framing_err    (framing_err),
        .err_clr        (err_clr),
        .data_out_ready (data_out_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    // Reference model: bits counted as they arrive, byte value built by
    // weighting each bit with its arrival position, storage as a queue.
    logic [7:0] q[$];
    int         nb = 0;
    int         acc = 0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    int         checks = 0;
    int         errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       pop_now;
        logic       have_push;
        logic [7:0] pv;
        logic [7:0] dropped;
        logic       fset;
        logic       oset;
        if (!rst_n) begin
            q.delete();
            nb     = 0;
            acc    = 0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            return;
        end
        pop_now   = (q.size() > 0) && data_out_ready;
        have_push = 1'b0;
        pv        = 8'h00;
        fset      = 1'b0;
        oset      = 1'b0;
        if (done) begin
            if (nb == 8) begin
                if (framing_err) fset = 1'b1;
                else begin
                    have_push = 1'b1;
                    pv        = acc[7:0];
                end
            end
            nb  = 0;
            acc = 0;
        end else if (bit_ready && nb < 8) begin
            acc = acc + (int'(rx_bit) << nb);
            nb  = nb + 1;
        end
        if (pop_now) dropped = q.pop_front();
        if (have_push) begin
            if (q.size() < CAP) q.push_back(pv);
            else oset = 1'b1;
        end
        m_ferr = fset | (m_ferr & ~err_clr);
        m_ovr  = oset | (m_ovr & ~err_clr);
    endtask

    task automatic compare();
        chk("valid", data_out_valid, q.size() > 0);
        if (q.size() > 0) chk("data", data_out, q[0]);
        chk("frame_err", frame_err, m_ferr);
        chk("overrun_err", overrun_err, m_ovr);
    endtask

    // One cycle: model absorbs the rising edge, outputs compared at the
    // falling edge; callers change inputs only after tick returns.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send_bit(input logic b);
        bit_ready = 1'b1;
        rx_bit    = b;
        tick();
        bit_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic fe, input int nbits, input logic rdy_at_done);
        for (int i = 0; i < nbits; i++) send_bit(v[i]);
        done           = 1'b1;
        framing_err    = fe;
        data_out_ready = rdy_at_done;
        tick();
        done           = 1'b0;
        framing_err    = 1'b0;
        data_out_ready = 1'b0;
    endtask

    task automatic pop_one();
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] ev;

        // Reset values
        tick();
        tick();
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_out_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Good frame 0xA5: valid the cycle after done, ready pops it
        send_frame(8'hA5, 1'b0, 8, 1'b0);
        chk("a5_valid", data_out_valid, 1'b1);
        chk("a5_data", data_out, 8'hA5);
        pop_one();
        chk("a5_popped", data_out_valid, 1'b0);

        // Bad stop bit: dropped, frame_err set, then cleared
        send_frame(8'h3C, 1'b1, 8, 1'b0);
        chk("fe_valid", data_out_valid, 1'b0);
        chk("fe_flag", frame_err, 1'b1);
        pulse_clr();
        chk("fe_clr", frame_err, 1'b0);

        // Overrun with no reader
`ifdef UART_RX_FIFO_EN
        for (int k = 1; k <= 5; k++) send_frame(8'(17 * k), 1'b0, 8, 1'b0);
        chk("ovr_flag", overrun_err, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            ev = 8'(17 * k);
            chk("fifo_order", data_out, ev);
            pop_one();
        end
`else
        send_frame(8'h11, 1'b0, 8, 1'b0);
        send_frame(8'h22, 1'b0, 8, 1'b0);
        chk("ovr_keep", data_out, 8'h11);
        chk("ovr_flag", overrun_err, 1'b1);
        pop_one();
`endif
        chk("ovr_drained", data_out_valid, 1'b0);
        pulse_clr();
        chk("ovr_clr", overrun_err, 1'b0);

        // Full storage, done coincides with a pop: new byte accepted
        for (int k = 0; k < CAP; k++) send_frame(8'(8'h60 + k), 1'b0, 8, 1'b0);
        send_frame(8'h77, 1'b0, 8, 1'b1);
        chk("full_pop_ovr", overrun_err, 1'b0);
        for (int k = 0; k < CAP; k++) begin
            ev = (k == CAP - 1) ? 8'h77 : 8'(8'h61 + k);
            chk("full_pop_data", data_out, ev);
            pop_one();
        end
        chk("full_pop_empty", data_out_valid, 1'b0);

        // Short frame dropped silently; next frame intact
        send_frame(8'h1F, 1'b0, 5, 1'b0);
        chk("short_valid", data_out_valid, 1'b0);
        chk("short_ferr", frame_err, 1'b0);
        chk("short_ovr", overrun_err, 1'b0);
        send_frame(8'h5A, 1'b0, 8, 1'b0);
        chk("5a_valid", data_out_valid, 1'b1);
        chk("5a_data", data_out, 8'h5A);
        pop_one();

        // Reset mid-frame with a byte stored
        send_frame(8'h42, 1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_valid", data_out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", data_out_valid, 1'b0);
        send_frame(8'hFF, 1'b0, 8, 1'b0);
        chk("ff_data", data_out, 8'hFF);
        pop_one();

        // Randomized strobes, including bit_ready+done collisions
        for (int n = 0; n < 4000; n++) begin
            bit_ready      = ($urandom_range(0, 9) < 7);
            rx_bit         = $urandom_range(0, 1);
            done           = ($urandom_range(0, 24) == 0);
            framing_err    = ($urandom_range(0, 3) == 0);
            err_clr        = ($urandom_range(0, 29) == 0);
            data_out_ready = (n < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
            tick();
        end
        bit_ready      = 1'b0;
        done           = 1'b0;
        framing_err    = 1'b0;
        err_clr        = 1'b0;
        data_out_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
